count_seq_checker: RTL and testbench
====================================

Name: count_seq_checker

Overview:
- Hardware monitor for the free-running up-counter output: receives a count stream and checks that each sample is the previous sample plus one, modulo 2^WIDTH.
- Acquires lock on the stream, then flags every break in sequence and keeps a saturating error tally.
- Sits on the receive side of a counter, on-chip or on a bench, as the consumer of the counter's count bus.

Parameters:
- WIDTH, 2, width of the checked count bus.
- ERR_W, 8, width of the saturating error counter.
- LOCK_CNT, 2, consecutive correct increments needed to enter LOCKED. Legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- count_in  input  WIDTH  count sample under check.
- count_valid  input  1  count_in is sampled on this edge when 1.
- locked  output  1  checker is in LOCKED state.
- err_pulse  output  1  one-cycle pulse per sequence error detected while locked.
- err_count  output  ERR_W  number of errors, saturating at all-ones.
- expected  output  WIDTH  value predicted for the next valid sample.
- first_bad  output  2*WIDTH  {expected, count_in} of the first error since reset (see Optional Feature).

Behaviour:
- Reset: synchronous, applied when rst_n==0 at a rising clk edge. Every output is registered and resets as follows:
  - state=IDLE, locked=0, err_pulse=0, err_count=0, expected=0, first_bad=0.
  - Internal run counter = 0.
- Reset mid-operation discards state immediately. The first valid sample after reset is treated as a seed only.
- count_valid==0:
  - state, expected, run counter and err_count hold.
  - err_pulse=0.
- All arithmetic is modulo 2^WIDTH. Wrap from all-ones to 0 is a legal increment, never an error.
- FSM, evaluated only on edges with count_valid==1:
  - IDLE: expected<=count_in+1; run<=0; go to ACQUIRE. Never an error.
  - ACQUIRE, match (count_in==expected): expected<=expected+1; run<=run+1. If run+1==LOCK_CNT, go to LOCKED and set locked<=1.
  - ACQUIRE, mismatch: reseed with expected<=count_in+1 and run<=0. No error is counted and err_pulse stays 0.
  - LOCKED, match: expected<=expected+1; stay in LOCKED.
  - LOCKED, mismatch:
    - err_pulse<=1 for exactly one cycle.
    - err_count<=err_count+1, unless already all-ones.
    - expected<=count_in+1; run<=0.
    - locked<=0; go to ACQUIRE.
- Latency: locked, err_pulse, err_count and expected all reflect a sample in the cycle after the edge that sampled it.
- Back-to-back errors: each LOCKED mismatch produces its own pulse. A second error cannot occur until relock, so at least LOCK_CNT+1 valid samples separate pulses.
- Run counter width: clog2(LOCK_CNT+1) bits. It never exceeds LOCK_CNT.

Optional Feature:
- Macro: COUNT_SEQ_CHK_CAPTURE_EN.
- Defined: on the first LOCKED mismatch after reset, first_bad<={expected, count_in} is captured on that edge. It then holds until reset; later errors do not overwrite it.
- Undefined: first_bad is tied to 0, no capture registers are built, and the port remains present.

Test Plan (WIDTH=2, LOCK_CNT=2, ERR_W=8 unless noted):
1. Release reset, then send valid samples 0,1,2,3,0,1 on consecutive cycles.
   - locked rises the cycle after sample 2 is taken.
   - err_count stays 0 through the 3->0 wrap.
   - expected tracks 1,2,3,0,1,2.
2. While locked, after sample 1 send 3 (expected 2), then 0,1.
   - err_pulse high for exactly one cycle and err_count=1.
   - locked=0 after the 3, then locked=1 again after the 1.
   - With COUNT_SEQ_CHK_CAPTURE_EN defined: first_bad={2'd2,2'd3}, still holding after a second forced error.
3. In ACQUIRE (after seed 0), send 2 then 3, 0.
   - No err_pulse and err_count=0.
   - Reseed to expected=3, then lock after the 0.
4. Samples 0, then count_valid=0 for 3 cycles with count_in=2 driven, then samples 1, 2.
   - Idle cycles are ignored, locked=1 after the 2, no error.
5. With ERR_W=2: lock, then force 5 separated errors, relocking between each.
   - err_count goes 1,2,3,3,3.
   - err_pulse fires 5 times.
6. While locked with err_count=1, drive rst_n=0 for one edge, then samples 3,0,1.
   - All outputs are 0 after the reset edge.
   - The 3 is treated as a seed with no error.
   - locked=1 after the 1.

Source files
------------

// File: rtl/count_seq_checker_if.sv
// Count-stream bundle between a counter (master) and the sequence checker
// (slave). The master drives the samples and the slave returns its lock and
// error status.
interface count_seq_checker_if #(
  parameter int WIDTH = 2,
  parameter int ERR_W = 8
);
  logic [WIDTH-1:0]   count_in;
  logic               count_valid;
  logic               locked;
  logic               err_pulse;
  logic [ERR_W-1:0]   err_count;
  logic [WIDTH-1:0]   expected;
  logic [2*WIDTH-1:0] first_bad;

  modport master (
    output count_in, count_valid,
    input  locked, err_pulse, err_count, expected, first_bad
  );

  modport slave (
    input  count_in, count_valid,
    output locked, err_pulse, err_count, expected, first_bad
  );
endinterface

// File: rtl/count_seq_checker.sv
// Sequence checker for a free-running up-counter.
// It seeds on the first valid sample. It locks after LOCK_CNT consecutive
// +1 steps (modulo 2^WIDTH). Once locked, it flags every break with a
// one-cycle pulse and bumps a saturating error tally.
// Optional build macro COUNT_SEQ_CHK_CAPTURE_EN: captures {expected, count_in}
// of the first locked mismatch after reset on first_bad. Without it,
// first_bad reads 0 and no capture registers exist.
module count_seq_checker #(
  parameter int WIDTH    = 2,
  parameter int ERR_W    = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  count_seq_checker_if.slave bus
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t             state;
  logic               locked_q;
  logic               err_pulse_q;
  logic [ERR_W-1:0]   err_count_q;
  logic [WIDTH-1:0]   expected_q;
  logic [RUN_W-1:0]   run_q;

  logic               match;
  logic [RUN_W-1:0]   run_nxt;

  // Next count value, wrapping from all-ones to zero.
  function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
    return v + WIDTH'(1);
  endfunction

  // Error tally increment that sticks at all-ones.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign match   = (bus.count_in == expected_q);
  assign run_nxt = run_q + RUN_W'(1);

  // Lock/acquire FSM. Only valid samples advance it, and every output is registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      expected_q  <= '0;
      run_q       <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (bus.count_valid) begin
        unique case (state)
          IDLE: begin
            expected_q <= wrap_inc(bus.count_in);
            run_q      <= '0;
            state      <= ACQUIRE;
          end
          ACQUIRE: begin
            if (match) begin
              expected_q <= wrap_inc(expected_q);
              run_q      <= run_nxt;
              if (run_nxt == LOCK_RUN) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              // A break while acquiring is not an error: reseed silently.
              expected_q <= wrap_inc(bus.count_in);
              run_q      <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              expected_q <= wrap_inc(expected_q);
            end else begin
              err_pulse_q <= 1'b1;
              err_count_q <= sat_inc(err_count_q);
              expected_q  <= wrap_inc(bus.count_in);
              run_q       <= '0;
              locked_q    <= 1'b0;
              state       <= ACQUIRE;
            end
          end
          default: begin
            state    <= IDLE;
            locked_q <= 1'b0;
            run_q    <= '0;
          end
        endcase
      end
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.expected  = expected_q;

`ifdef COUNT_SEQ_CHK_CAPTURE_EN
  logic               captured_q;
  logic [2*WIDTH-1:0] first_bad_q;

  // Freeze the first locked mismatch after reset. Later errors leave it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      captured_q  <= 1'b0;
      first_bad_q <= '0;
    end else if (bus.count_valid && (state == LOCKED) && !match && !captured_q) begin
      captured_q  <= 1'b1;
      first_bad_q <= {expected_q, bus.count_in};
    end
  end

  assign bus.first_bad = first_bad_q;
`else
  assign bus.first_bad = '0;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: two instances (ERR_W=8 and ERR_W=2) share
// one directed stimulus stream. Each driven cycle pushes its hand-computed
// expected outputs to a scoreboard queue. A monitor pops and compares after
// the edge.
module tb_count_seq_checker;

  logic clk = 1'b0;
  logic rst_n;

  count_seq_checker_if #(.WIDTH(2), .ERR_W(8)) if8 ();
  count_seq_checker_if #(.WIDTH(2), .ERR_W(2)) if2 ();

  count_seq_checker #(.WIDTH(2), .ERR_W(8), .LOCK_CNT(2)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8.slave)
  );

  count_seq_checker #(.WIDTH(2), .ERR_W(2), .LOCK_CNT(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lk;
    logic       ep;
    int         ec;
    logic [1:0] ex;
    logic [3:0] fb;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   row   = 0;

  task automatic chk(input string name, input int r, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s row=%0d actual=%0d required=%0d", name, r, act, req);
    end
  endtask

  // Apply one cycle of stimulus, then log its expected outputs after the edge.
  task automatic step(input logic r, input logic v, input logic [1:0] c,
                      input logic lk, input logic ep, input int ec,
                      input logic [1:0] ex, input logic [3:0] fb);
    exp_t e;
    rst_n           = r;
    if8.count_valid = v;
    if2.count_valid = v;
    if8.count_in    = c;
    if2.count_in    = c;
    @(posedge clk);
    e.lk = lk;
    e.ep = ep;
    e.ec = ec;
    e.ex = ex;
`ifdef COUNT_SEQ_CHK_CAPTURE_EN
    e.fb = fb;
`else
    e.fb = 4'd0;
`endif
    sbq.push_back(e);
    #1;
  endtask

  // Monitor: compare both instances against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        row++;
        chk("locked8",    row, int'(if8.locked),    int'(e.lk));
        chk("err_pulse8", row, int'(if8.err_pulse), int'(e.ep));
        chk("err_count8", row, int'(if8.err_count), (e.ec > 255) ? 255 : e.ec);
        chk("expected8",  row, int'(if8.expected),  int'(e.ex));
        chk("first_bad8", row, int'(if8.first_bad), int'(e.fb));
        chk("locked2",    row, int'(if2.locked),    int'(e.lk));
        chk("err_pulse2", row, int'(if2.err_pulse), int'(e.ep));
        chk("err_count2", row, int'(if2.err_count), (e.ec > 3) ? 3 : e.ec);
        chk("expected2",  row, int'(if2.expected),  int'(e.ex));
        chk("first_bad2", row, int'(if2.first_bad), int'(e.fb));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    if8.count_valid = 1'b0; if2.count_valid = 1'b0;
    if8.count_in = 2'd0;    if2.count_in = 2'd0;

    // Reset state
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Lock and wrap: 0,1,2,3,0,1
    step(1, 1, 0, 0, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0, 0, 2, 0);
    step(1, 1, 2, 1, 0, 0, 3, 0);
    step(1, 1, 3, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 1, 0);
    step(1, 1, 1, 1, 0, 0, 2, 0);

    // Locked error (3 while expecting 2), relock, second error
    step(1, 1, 3, 0, 1, 1, 0, 4'b1011);
    step(1, 1, 0, 0, 0, 1, 1, 4'b1011);
    step(1, 1, 1, 1, 0, 1, 2, 4'b1011);
    step(1, 1, 0, 0, 1, 2, 1, 4'b1011);
    step(1, 1, 1, 0, 0, 2, 2, 4'b1011);
    step(1, 1, 2, 1, 0, 2, 3, 4'b1011);

    // Reset while locked, then 3 as seed, relock after 1
    step(0, 1, 3, 0, 0, 0, 0, 0);
    step(1, 1, 3, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1, 0);
    step(1, 1, 1, 1, 0, 0, 2, 0);

    // Acquire mismatch reseeds silently: 0, 2, 3, 0
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1, 0);
    step(1, 1, 2, 0, 0, 0, 3, 0);
    step(1, 1, 3, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 1, 0);

    // Invalid cycles ignored: 0, three idle cycles with 2 driven, 1, 2
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 2, 0, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0, 0, 2, 0);
    step(1, 1, 2, 1, 0, 0, 3, 0);

    // Five separated errors with relock in between, saturating the narrow tally
    for (int k = 1; k <= 5; k++) begin
      step(1, 1, 0, 0, 1, k, 1, 4'b1100);
      step(1, 0, 0, 0, 0, k, 1, 4'b1100);
      step(1, 1, 1, 0, 0, k, 2, 4'b1100);
      step(1, 1, 2, 1, 0, k, 3, 4'b1100);
    end
    step(1, 1, 3, 1, 0, 5, 0, 4'b1100);

    step(1, 0, 0, 1, 0, 5, 0, 4'b1100);
    repeat (3) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
